// File: rtl/os_pkg.sv
// -----------------------------------------------------------------------------
// os_pkg
// Shared definitions for the overlap-save output stage:
//   - default frame length / hop size
//   - input framing FSM state encoding
//   - requantization shift-amount helper
// -----------------------------------------------------------------------------
package os_pkg;

  localparam int unsigned NFFT_DEF = 32;
  localparam int unsigned NHOP_DEF = 16;

  // Input framing FSM: discard the aliased first half, keep the second half.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DISCARD = 2'd1,
    S_KEEP    = 2'd2
  } in_state_e;

  // Number of LSBs dropped when narrowing a WI-bit sample to WN bits.
  function automatic int unsigned requant_shift(input int unsigned wi,
                                                input int unsigned wn);
    return (wi > wn) ? (wi - wn) : 0;
  endfunction

endpackage

// File: rtl/os_requant.sv
// -----------------------------------------------------------------------------
// os_requant
// Combinational requantizer, signed WI bits -> signed WN bits.
//   Default build : arithmetic right shift by WI-WN (truncation toward -inf).
//   OS_DISCARD_ROUND_EN defined : add half an output LSB before the shift and
//                                 saturate to the WN-bit signed range.
//   WI == WN : pass-through in both builds.
// Ports:
//   data_i  in  WI  signed input sample
//   data_o  out WN  signed requantized sample
// -----------------------------------------------------------------------------
module os_requant
  import os_pkg::*;
#(
  parameter int unsigned WI = 16,
  parameter int unsigned WN = 16
) (
  input  logic [WI-1:0] data_i,
  output logic [WN-1:0] data_o
);

  localparam int unsigned SH = requant_shift(WI, WN);

  generate
    if (SH == 0) begin : g_pass
      assign data_o = data_i[WN-1:0];
    end else begin : g_shift
`ifdef OS_DISCARD_ROUND_EN
      // One guard bit above the input so the rounding add cannot wrap.
      localparam logic [WI:0] RND = {{WI{1'b0}}, 1'b1} << (SH - 1);

      logic [WI:0] sum;
      logic [WI:0] shifted;

      // NOTE: every output of a combinational block is assigned on every path
      // (here via the full if/else chain) so no latch is inferred.
      always_comb begin
        sum     = {data_i[WI-1], data_i} + RND;
        shifted = $unsigned($signed(sum) >>> SH);
        // In range when all bits above the WN-bit sign position agree.
        if ((shifted[WI:WN-1] == '0) || (shifted[WI:WN-1] == '1)) begin
          data_o = shifted[WN-1:0];
        end else if (shifted[WI]) begin
          data_o = {1'b1, {(WN-1){1'b0}}};
        end else begin
          data_o = {1'b0, {(WN-1){1'b1}}};
        end
      end
`else
      // Arithmetic shift then keep WN bits == take the top WN input bits.
      logic unused_lsb;
      assign unused_lsb = ^data_i[SH-1:0];
      assign data_o     = data_i[WI-1:SH];
`endif
    end
  endgenerate

endmodule

// File: rtl/os_discard_output.sv
// -----------------------------------------------------------------------------
// os_discard_output
// Overlap-save output stage. Takes NFFT-sample IFFT frames, drops the first
// NHOP (circularly aliased) samples, requantizes the last NHOP samples from
// WI to WN bits into a two-bank ping-pong buffer, and streams each full bank
// out under a valid/ready handshake.
// Optional build macro: OS_DISCARD_ROUND_EN (round + saturate in os_requant).
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active low
//   valid_in   in   1   input sample strobe (no backpressure)
//   start_in   in   1   first sample of a frame, qualified by valid_in
//   data_in    in   WI  signed input sample
//   out_ready  in   1   downstream accepts data_out
//   valid_out  out  1   data_out is valid
//   data_out   out  WN  signed output sample
//   frame_err  out  1   one-cycle pulse on a framing violation
//   overflow   out  1   sticky: a kept frame was dropped (both banks full)
// -----------------------------------------------------------------------------
module os_discard_output
  import os_pkg::*;
#(
  parameter int unsigned WN   = 16,
  parameter int unsigned WI   = 16,
  parameter int unsigned NFFT = NFFT_DEF,
  parameter int unsigned NHOP = NHOP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic          start_in,
  input  logic [WI-1:0] data_in,
  input  logic          out_ready,
  output logic          valid_out,
  output logic [WN-1:0] data_out,
  output logic          frame_err,
  output logic          overflow
);

  localparam int unsigned IW = $clog2(NFFT);
  localparam int unsigned HW = $clog2(NHOP);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  in_state_e     state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          wr_bank_q, wr_bank_d;
  logic          drop_q, drop_d;         // current frame's kept half is dropped
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;

  logic [1:0]    full_q, full_d;         // bank holds a complete frame
  logic [1:0]    rdy_q, rdy_d;           // full flag delayed one cycle for reader
  logic          rd_bank_q, rd_bank_d;
  logic [HW-1:0] rd_idx_q, rd_idx_d;
  logic          vo_q, vo_d;
  logic [WN-1:0] do_q, do_d;
  logic          last_q, last_d;         // output register holds a bank's last sample
  logic          ob_q, ob_d;             // bank the output register sample came from

  logic [1:0]    set_vec;                // bank becomes full this cycle
  logic [1:0]    clr_vec;                // bank becomes empty this cycle
  logic          mem_we;
  logic          wr_busy;
  logic          xfer;
  logic          load;
  logic [WN-1:0] rq_data;
  logic [WN-1:0] rd_data;

  logic [WN-1:0] mem_q [2][NHOP];

  // ---------------------------------------------------------------------------
  // Requantization ahead of the buffer, so banks store WN-bit samples
  // ---------------------------------------------------------------------------
  os_requant #(
    .WI (WI),
    .WN (WN)
  ) u_requant (
    .data_i (data_in),
    .data_o (rq_data)
  );

  // ---------------------------------------------------------------------------
  // Input FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wr_bank_q   <= 1'b0;
      drop_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_bank_q   <= wr_bank_d;
      drop_q      <= drop_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Input FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (valid_in) begin
      if (start_in) begin
        state_d = S_DISCARD;  // sample 0 is always discarded
      end else begin
        unique case (state_q)
          S_IDLE:    state_d = S_IDLE;
          S_DISCARD: if (idx_q == IW'(NHOP - 1)) state_d = S_KEEP;
          S_KEEP:    if (idx_q == IW'(NFFT - 1)) state_d = S_IDLE;
          default:   state_d = S_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Input FSM: outputs / datapath control
  // ---------------------------------------------------------------------------
  // A bank draining this very cycle already counts as free for the writer.
  assign wr_busy = full_q[wr_bank_q] & ~clr_vec[wr_bank_q];

  always_comb begin
    idx_d       = idx_q;
    wr_bank_d   = wr_bank_q;
    drop_d      = drop_q;
    frame_err_d = 1'b0;
    overflow_d  = overflow_q;
    set_vec     = 2'b00;
    mem_we      = 1'b0;
    if (valid_in) begin
      if (start_in) begin
        // A restart abandons any partially written bank: it is never marked full.
        idx_d       = IW'(1);
        drop_d      = 1'b0;
        frame_err_d = (state_q != S_IDLE);
      end else begin
        unique case (state_q)
          S_IDLE: begin
            frame_err_d = 1'b1;
          end
          S_DISCARD: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IW'(NHOP - 1)) begin
              // Decide once for the whole kept half so a bank is never partially
              // overwritten.
              drop_d = wr_busy;
              if (wr_busy) overflow_d = 1'b1;
            end
          end
          S_KEEP: begin
            mem_we = ~drop_q;
            idx_d  = idx_q + 1'b1;
            if (idx_q == IW'(NFFT - 1)) begin
              idx_d = '0;
              if (!drop_q) begin
                set_vec[wr_bank_q] = 1'b1;
                wr_bank_d          = ~wr_bank_q;
              end
            end
          end
          default: begin
            idx_d = '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Ping-pong buffer. Kept index idx-NHOP equals the low HW bits of idx since
  // NHOP = NFFT/2.
  // ---------------------------------------------------------------------------
  // NOTE: the sample memory has no reset; the full flags alone say which
  // contents are meaningful, and leaving it unreset keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_bank_q][idx_q[HW-1:0]] <= rq_data;
    end
  end

  assign rd_data = mem_q[rd_bank_q][rd_idx_q];

  // ---------------------------------------------------------------------------
  // Output side
  // ---------------------------------------------------------------------------
  assign xfer    = vo_q & out_ready;
  // A bank is released only once its last sample has actually been accepted.
  assign clr_vec = (xfer & last_q) ? (2'b01 << ob_q) : 2'b00;
  // Refill the output register whenever it is empty or being emptied.
  assign load    = (~vo_q | out_ready) & rdy_q[rd_bank_q] & ~clr_vec[rd_bank_q];

  always_comb begin
    full_d    = (full_q & ~clr_vec) | set_vec;
    rdy_d     = full_q & ~clr_vec;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    vo_d      = vo_q;
    do_d      = do_q;
    last_d    = last_q;
    ob_d      = ob_q;
    if (load) begin
      vo_d     = 1'b1;
      do_d     = rd_data;
      ob_d     = rd_bank_q;
      last_d   = (rd_idx_q == HW'(NHOP - 1));
      rd_idx_d = rd_idx_q + 1'b1;
      if (rd_idx_q == HW'(NHOP - 1)) rd_bank_d = ~rd_bank_q;
    end else if (xfer) begin
      vo_d   = 1'b0;
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q    <= 2'b00;
      rdy_q     <= 2'b00;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      vo_q      <= 1'b0;
      do_q      <= '0;
      last_q    <= 1'b0;
      ob_q      <= 1'b0;
    end else begin
      full_q    <= full_d;
      rdy_q     <= rdy_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
      vo_q      <= vo_d;
      do_q      <= do_d;
      last_q    <= last_d;
      ob_q      <= ob_d;
    end
  end

  assign valid_out = vo_q;
  assign data_out  = do_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_os_discard_output.sv
// -----------------------------------------------------------------------------
// tb_os_discard_output
// Directed bench for os_discard_output. A default-parameter instance covers
// framing, buffering and handshake; a WI=18/WN=16 instance covers
// requantization (expected values follow OS_DISCARD_ROUND_EN).
// -----------------------------------------------------------------------------
module tb_os_discard_output;

  localparam int NFFT = 32;
  localparam int NHOP = 16;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Main instance (WI = WN = 16)
  logic        valid_in, start_in, out_ready;
  logic [15:0] data_in;
  logic        valid_out, frame_err, overflow;
  logic [15:0] data_out;

  // Requant instance (WI = 18, WN = 16)
  logic        rq_valid_in, rq_start_in, rq_out_ready;
  logic [17:0] rq_data_in;
  logic        rq_valid_out, rq_frame_err, rq_overflow;
  logic [15:0] rq_data_out;

  int          n_tests = 0;
  int          n_fail  = 0;

  logic [15:0] got_q[$];
  logic [15:0] rq_got_q[$];
  int          stall_err  = 0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;
  int          sz;

  os_discard_output #(.WN(16), .WI(16), .NFFT(NFFT), .NHOP(NHOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .start_in  (start_in),
    .data_in   (data_in),
    .out_ready (out_ready),
    .valid_out (valid_out),
    .data_out  (data_out),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  os_discard_output #(.WN(16), .WI(18), .NFFT(NFFT), .NHOP(NHOP)) dut_rq (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (rq_valid_in),
    .start_in  (rq_start_in),
    .data_in   (rq_data_in),
    .out_ready (rq_out_ready),
    .valid_out (rq_valid_out),
    .data_out  (rq_data_out),
    .frame_err (rq_frame_err),
    .overflow  (rq_overflow)
  );

  // Transfer monitor on the falling edge: valid/ready seen here are the values
  // the next rising edge acts on. Also records any change while stalled.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(valid_out && data_out == prev_data)) stall_err++;
      if (valid_out && out_ready) got_q.push_back(data_out);
      if (rq_valid_out && rq_out_ready) rq_got_q.push_back(rq_data_out);
      prev_stall = valid_out && !out_ready;
      prev_data  = data_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input int d);
    valid_in = 1'b1;
    start_in = s;
    data_in  = 16'(d);
    tick();
    valid_in = 1'b0;
    start_in = 1'b0;
  endtask

  task automatic rq_drive(input bit s, input logic [17:0] d);
    rq_valid_in = 1'b1;
    rq_start_in = s;
    rq_data_in  = d;
    tick();
    rq_valid_in = 1'b0;
    rq_start_in = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < NFFT; i++) drive(i == 0, base + i);
  endtask

  task automatic wait_count(input int n);
    for (int c = 0; c < 400 && got_q.size() < n; c++) tick();
  endtask

  // Expects got_q[off .. off+15] == base+16 .. base+31
  task automatic expect_seq(input string tag, input int off, input int base);
    for (int k = 0; k < NHOP; k++)
      check($sformatf("%s[%0d]", tag, k), 32'(got_q[off + k]), 32'(base + NHOP + k));
  endtask

  initial begin
    rst          = 1'b0;
    valid_in     = 1'b0;
    start_in     = 1'b0;
    data_in      = '0;
    out_ready    = 1'b1;
    rq_valid_in  = 1'b0;
    rq_start_in  = 1'b0;
    rq_data_in   = '0;
    rq_out_ready = 1'b1;

    // ---- Reset state
    repeat (3) tick();
    check("rst valid_out", 32'(valid_out), 32'd0);
    check("rst data_out",  32'(data_out),  32'd0);
    check("rst frame_err", 32'(frame_err), 32'd0);
    check("rst overflow",  32'(overflow),  32'd0);
    rst = 1'b1;
    tick();

    // ---- Setup: one frame, first output two edges after sample 31
    got_q.delete();
    send_frame(0);
    check("lat edge0 valid", 32'(valid_out), 32'd0);
    tick();
    check("lat edge1 valid", 32'(valid_out), 32'd0);
    tick();
    check("lat edge2 valid", 32'(valid_out), 32'd1);
    check("lat edge2 data",  32'(data_out),  32'd16);
    wait_count(NHOP);
    repeat (20) tick();
    check("setup count", 32'(got_q.size()), 32'(NHOP));
    expect_seq("setup", 0, 0);
    check("setup frame_err", 32'(frame_err), 32'd0);
    check("setup overflow",  32'(overflow),  32'd0);

    // ---- Backpressure: out_ready 1,0,0,1,...
    got_q.delete();
    stall_err = 0;
    send_frame(0);
    for (int c = 0; c < 400 && got_q.size() < NHOP; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    out_ready = 1'b1;
    repeat (20) tick();
    check("bp count", 32'(got_q.size()), 32'(NHOP));
    expect_seq("bp", 0, 0);
    check("bp stall stable", 32'(stall_err), 32'd0);

    // ---- Back-to-back frames
    got_q.delete();
    send_frame(0);
    send_frame(100);
    send_frame(200);
    wait_count(3 * NHOP);
    repeat (20) tick();
    check("b2b count", 32'(got_q.size()), 32'(3 * NHOP));
    expect_seq("b2b f0", 0, 0);
    expect_seq("b2b f1", NHOP, 100);
    expect_seq("b2b f2", 2 * NHOP, 200);
    check("b2b overflow", 32'(overflow), 32'd0);

    // ---- Overflow: three frames with the sink stalled
    got_q.delete();
    out_ready = 1'b0;
    send_frame(0);
    send_frame(100);
    check("ovf after f2", 32'(overflow), 32'd0);
    for (int i = 0; i < NFFT; i++) begin
      drive(i == 0, 200 + i);
      if (i == NHOP - 2) check("ovf before keep", 32'(overflow), 32'd0);
      if (i == NHOP - 1) check("ovf at keep",     32'(overflow), 32'd1);
    end
    check("ovf held valid", 32'(valid_out), 32'd1);
    check("ovf held data",  32'(data_out),  32'd16);
    out_ready = 1'b1;
    wait_count(2 * NHOP);
    repeat (40) tick();
    check("ovf count", 32'(got_q.size()), 32'(2 * NHOP));
    expect_seq("ovf f1", 0, 0);
    expect_seq("ovf f2", NHOP, 100);
    check("ovf sticky", 32'(overflow), 32'd1);

    // Reset clears the sticky flag
    rst = 1'b0;
    #1;
    check("rst clears overflow", 32'(overflow), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // ---- Framing errors
    got_q.delete();
    for (int i = 0; i < 10; i++) drive(i == 0, 500 + i);
    drive(1'b1, 1000);
    check("ferr restart discard", 32'(frame_err), 32'd1);
    for (int j = 1; j < NFFT; j++) begin
      drive(1'b0, 1000 + j);
      if (j == 1) check("ferr pulse end", 32'(frame_err), 32'd0);
    end
    wait_count(NHOP);
    drive(1'b0, 7);
    check("ferr idle sample", 32'(frame_err), 32'd1);
    tick();
    check("ferr idle end", 32'(frame_err), 32'd0);
    for (int i = 0; i < 20; i++) drive(i == 0, 2000 + i);
    drive(1'b1, 3000);
    check("ferr restart keep", 32'(frame_err), 32'd1);
    for (int j = 1; j < NFFT; j++) drive(1'b0, 3000 + j);
    wait_count(2 * NHOP);
    repeat (40) tick();
    check("ferr count", 32'(got_q.size()), 32'(2 * NHOP));
    expect_seq("ferr f1", 0, 1000);
    expect_seq("ferr f2", NHOP, 3000);
    check("ferr overflow", 32'(overflow), 32'd0);

    // ---- Requantization, WI=18 -> WN=16
    rq_got_q.delete();
    for (int i = 0; i < NFFT; i++) begin
      logic [17:0] v;
      v = 18'd0;
      if (i == 16) v = 18'd6;
      if (i == 17) v = 18'd131070;
      if (i == 18) v = 18'h3FFFB;  // -5
      rq_drive(i == 0, v);
    end
    for (int c = 0; c < 400 && rq_got_q.size() < NHOP; c++) tick();
    check("rq count", 32'(rq_got_q.size()), 32'(NHOP));
`ifdef OS_DISCARD_ROUND_EN
    check("rq 6",      32'(rq_got_q[0]), 32'h0000_0002);
    check("rq 131070", 32'(rq_got_q[1]), 32'h0000_7FFF);
    check("rq -5",     32'(rq_got_q[2]), 32'h0000_FFFF);
`else
    check("rq 6",      32'(rq_got_q[0]), 32'h0000_0001);
    check("rq 131070", 32'(rq_got_q[1]), 32'h0000_7FFF);
    check("rq -5",     32'(rq_got_q[2]), 32'h0000_FFFE);
`endif
    check("rq 0", 32'(rq_got_q[3]), 32'd0);

    // ---- Reset mid-drain
    got_q.delete();
    send_frame(0);
    wait_count(5);
    check("middrain valid before", 32'(valid_out), 32'd1);
    rst = 1'b0;
    #1;
    check("middrain valid_out", 32'(valid_out), 32'd0);
    check("middrain data_out",  32'(data_out),  32'd0);
    sz = got_q.size();
    tick();
    rst = 1'b1;
    repeat (40) tick();
    check("middrain no resume", 32'(got_q.size()), 32'(sz));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
